conv_mac_engine: RTL and testbench

Parametrised 2-D convolution engine and successor to the single-window convolver. It loads a KxK kernel once from kernel SRAM, then streams N consecutive KxK windows from window SRAM. For each window it computes the signed dot product and delivers post-processed results (shift, optional ReLU, saturation) over a valid/ready handshake. It sits between the NPU's SRAM banks and the result write-back path.

---
 rtl/conv_pkg.sv | 35 +++
 rtl/conv_mac_unit.sv | 42 ++++
 rtl/conv_mac_engine.sv | 196 +++++++++++++++++++
 tb/tb_conv_mac_engine.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types and post-processing helpers for the NPU compute blocks.
package conv_pkg;

  // Default kernel edge and its tap count; blocks derive their own from KERNEL_SIZE.
  localparam int unsigned KERNEL_SIZE_DEFAULT = 3;
  localparam int unsigned TAPS = KERNEL_SIZE_DEFAULT * KERNEL_SIZE_DEFAULT;

  typedef enum logic [2:0] {
    StIdle,
    StLoadKernel,
    StMac,
    StOutput,
    StFinish
  } conv_state_e;

  // Arithmetic shift, optional ReLU, then clamp into a signed 'width'-bit range.
  // Works on a 64-bit sign-extended accumulator so any ACC_WIDTH up to 64 fits;
  // the caller truncates the return value to its result width.
  function automatic logic signed [63:0] sat_narrow(input logic signed [63:0] acc,
                                                    input int unsigned        shift,
                                                    input logic               relu,
                                                    input int unsigned        width);
    logic signed [63:0] v;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    v  = acc >>> shift;
    if (relu && (v < 64'sd0)) v = 64'sd0;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) v = hi;
    else if (v < lo) v = lo;
    return v;
  endfunction

endpackage

// File: rtl/conv_mac_unit.sv
// Signed multiply-accumulate with synchronous clear (priority) and enable.
module conv_mac_unit
  import conv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ACC_WIDTH  = 24
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_clr,
  input  logic                         i_en,
  input  logic signed [DATA_WIDTH-1:0] i_a,
  input  logic signed [DATA_WIDTH-1:0] i_b,
  // acc + a*b; equals the next accumulator value whenever i_en is high
  output logic signed [ACC_WIDTH-1:0]  o_sum
);

  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0]    acc_q, acc_d;

  // Product, running sum and accumulator next-state.
  always_comb begin
    prod  = i_a * i_b;
    o_sum = acc_q + ACC_WIDTH'(prod);
    acc_d = acc_q;
    if (i_clr) begin
      acc_d = '0;
    end else if (i_en) begin
      acc_d = o_sum;
    end
  end

  // Accumulator register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/conv_mac_engine.sv
// Multi-window KxK convolution engine: loads the kernel once, then streams N
// windows through a MAC and hands post-processed results out over valid/ready.
module conv_mac_engine
  import conv_pkg::*;
#(
  parameter int unsigned KERNEL_SIZE = KERNEL_SIZE_DEFAULT,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned ACC_WIDTH   = 24,
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned CNT_WIDTH   = 8,
  parameter int unsigned SHIFT_WIDTH = 5
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_start,
  input  logic [ADDR_WIDTH-1:0]  i_kernel_base,
  input  logic [ADDR_WIDTH-1:0]  i_win_base,
  input  logic [CNT_WIDTH-1:0]   i_num_windows,
  input  logic [SHIFT_WIDTH-1:0] i_shift,
  input  logic                   i_relu_en,
  output logic [ADDR_WIDTH-1:0]  o_kernel_addr,
  input  logic [DATA_WIDTH-1:0]  i_kernel_data,
  output logic [ADDR_WIDTH-1:0]  o_win_addr,
  input  logic [DATA_WIDTH-1:0]  i_win_data,
  output logic [DATA_WIDTH-1:0]  o_result,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic                   o_busy,
  output logic                   o_done
);

  localparam int unsigned NumTaps = KERNEL_SIZE * KERNEL_SIZE;
  localparam int unsigned TcntW   = $clog2(NumTaps + 1);
  localparam int unsigned KidxW   = (NumTaps > 1) ? $clog2(NumTaps) : 1;
  // Last cycle that still advances the read address, and the final cycle of a phase.
  localparam logic [TcntW-1:0] TcntLastIssue = TcntW'(NumTaps - 1);
  localparam logic [TcntW-1:0] TcntEnd       = TcntW'(NumTaps);

  conv_state_e                  state_q, state_d;
  logic [TcntW-1:0]             tcnt_q, tcnt_d;
  logic [CNT_WIDTH-1:0]         win_q, win_d;
  logic [CNT_WIDTH-1:0]         num_q, num_d;
  logic [ADDR_WIDTH-1:0]        win_base_q, win_base_d;
  logic [ADDR_WIDTH-1:0]        kaddr_q, kaddr_d;
  logic [ADDR_WIDTH-1:0]        waddr_q, waddr_d;
  logic [SHIFT_WIDTH-1:0]       shift_q, shift_d;
  logic                         relu_q, relu_d;
  logic [DATA_WIDTH-1:0]        result_q, result_d;
  logic signed [DATA_WIDTH-1:0] kernel_q [NumTaps];
  logic signed [DATA_WIDTH-1:0] kernel_d [NumTaps];

  logic                         mac_clr, mac_en;
  logic [KidxW-1:0]             kidx;
  logic signed [DATA_WIDTH-1:0] mac_coef;
  logic signed [ACC_WIDTH-1:0]  mac_sum;

  // Data returning in phase cycle t belongs to tap t-1 (one-cycle SRAM latency).
  always_comb begin
    kidx     = KidxW'(tcnt_q - TcntW'(1));
    mac_coef = (tcnt_q != '0) ? kernel_q[kidx] : '0;
  end

  conv_mac_unit #(
    .DATA_WIDTH(DATA_WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_mac (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_clr(mac_clr),
    .i_en (mac_en),
    .i_a  (i_win_data),
    .i_b  (mac_coef),
    .o_sum(mac_sum)
  );

  // FSM next-state, address generation, kernel capture and result formation.
  always_comb begin
    state_d    = state_q;
    tcnt_d     = tcnt_q;
    win_d      = win_q;
    num_d      = num_q;
    win_base_d = win_base_q;
    kaddr_d    = kaddr_q;
    waddr_d    = waddr_q;
    shift_d    = shift_q;
    relu_d     = relu_q;
    result_d   = result_q;
    kernel_d   = kernel_q;
    mac_clr    = 1'b0;
    mac_en     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          num_d      = i_num_windows;
          win_base_d = i_win_base;
          shift_d    = i_shift;
          relu_d     = i_relu_en;
          win_d      = '0;
          tcnt_d     = '0;
          if (i_num_windows == '0) begin
            state_d = StFinish;
          end else begin
            state_d = StLoadKernel;
            kaddr_d = i_kernel_base;
          end
        end
      end

      StLoadKernel: begin
        if (tcnt_q != '0) kernel_d[kidx] = i_kernel_data;
        if (tcnt_q < TcntLastIssue) kaddr_d = kaddr_q + ADDR_WIDTH'(1);
        if (tcnt_q == TcntEnd) begin
          state_d = StMac;
          tcnt_d  = '0;
          waddr_d = win_base_q;
          mac_clr = 1'b1;
        end else begin
          tcnt_d = tcnt_q + TcntW'(1);
        end
      end

      StMac: begin
        mac_en = (tcnt_q != '0);
        if (tcnt_q < TcntLastIssue) waddr_d = waddr_q + ADDR_WIDTH'(1);
        if (tcnt_q == TcntEnd) begin
          // mac_sum already includes the last tap's product here.
          state_d  = StOutput;
          tcnt_d   = '0;
          result_d = DATA_WIDTH'(sat_narrow(64'(mac_sum), 32'(shift_q), relu_q, DATA_WIDTH));
        end else begin
          tcnt_d = tcnt_q + TcntW'(1);
        end
      end

      StOutput: begin
        if (i_ready) begin
          if (win_q == num_q - CNT_WIDTH'(1)) begin
            state_d = StFinish;
          end else begin
            // Windows are contiguous, so the next one starts right after the last pixel.
            win_d   = win_q + CNT_WIDTH'(1);
            state_d = StMac;
            tcnt_d  = '0;
            waddr_d = waddr_q + ADDR_WIDTH'(1);
            mac_clr = 1'b1;
          end
        end
      end

      StFinish: state_d = StIdle;

      default: state_d = StIdle;
    endcase
  end

  // State, configuration, kernel and result registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= StIdle;
      tcnt_q     <= '0;
      win_q      <= '0;
      num_q      <= '0;
      win_base_q <= '0;
      kaddr_q    <= '0;
      waddr_q    <= '0;
      shift_q    <= '0;
      relu_q     <= 1'b0;
      result_q   <= '0;
      for (int unsigned i = 0; i < NumTaps; i++) kernel_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      tcnt_q     <= tcnt_d;
      win_q      <= win_d;
      num_q      <= num_d;
      win_base_q <= win_base_d;
      kaddr_q    <= kaddr_d;
      waddr_q    <= waddr_d;
      shift_q    <= shift_d;
      relu_q     <= relu_d;
      result_q   <= result_d;
      kernel_q   <= kernel_d;
    end
  end

  // Status outputs decode straight from the state so reset clears them at once.
  always_comb begin
    o_kernel_addr = kaddr_q;
    o_win_addr    = waddr_q;
    o_result      = result_q;
    o_valid       = (state_q == StOutput);
    o_busy        = (state_q != StIdle);
    o_done        = (state_q == StFinish);
  end

endmodule

// File: tb/tb_conv_mac_engine.sv
// Scoreboard bench for conv_mac_engine: expected results are queued at start,
// a negedge monitor compares them as the DUT hands results out.
module tb_conv_mac_engine;

  localparam int K    = 3;
  localparam int TAPS = K * K;
  localparam int NOFIX = -100000;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_start;
  logic [7:0] i_kernel_base, i_win_base, i_num_windows;
  logic [4:0] i_shift;
  logic       i_relu_en;
  logic [7:0] o_kernel_addr, i_kernel_data, o_win_addr, i_win_data, o_result;
  logic       o_valid, i_ready, o_busy, o_done;

  conv_mac_engine #(
    .KERNEL_SIZE(K),
    .DATA_WIDTH (8),
    .ACC_WIDTH  (24),
    .ADDR_WIDTH (8),
    .CNT_WIDTH  (8),
    .SHIFT_WIDTH(5)
  ) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_start      (i_start),
    .i_kernel_base(i_kernel_base),
    .i_win_base   (i_win_base),
    .i_num_windows(i_num_windows),
    .i_shift      (i_shift),
    .i_relu_en    (i_relu_en),
    .o_kernel_addr(o_kernel_addr),
    .i_kernel_data(i_kernel_data),
    .o_win_addr   (o_win_addr),
    .i_win_data   (i_win_data),
    .o_result     (o_result),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_busy       (o_busy),
    .o_done       (o_done)
  );

  always #5 i_clk = ~i_clk;

  logic [7:0] kmem [256];
  logic [7:0] wmem [256];

  // Synchronous-read SRAMs: data for the address seen at an edge appears after it.
  always @(posedge i_clk) begin
    i_kernel_data <= kmem[o_kernel_addr];
    i_win_data    <= wmem[o_win_addr];
  end

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;
  int exp_q[$];
  int total_acc = 0;
  int acc_base = 0;
  int last_acc_cyc = 0;
  int start_cyc = 0;
  int run_id = 0;
  int st_win = -1;
  int st_len = 0;
  bit rand_ready = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: dot product of the kernel and window w, then shift, ReLU, clamp.
  function automatic int ref_window(int kb, int wb, int w, int sh, bit relu);
    longint acc = 0;
    for (int t = 0; t < TAPS; t++) begin
      acc += longint'($signed(kmem[(kb + t) % 256])) *
             longint'($signed(wmem[(wb + w * TAPS + t) % 256]));
    end
    acc = acc >>> sh;
    if (relu && acc < 0) acc = 0;
    if (acc > 127) acc = 127;
    if (acc < -128) acc = -128;
    return int'(acc);
  endfunction

  // Monitor: compares every presented result against the scoreboard head.
  always @(negedge i_clk) begin
    if (!i_rst && o_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_valid: got result %0d, expected no valid", $signed(o_result));
      end else if (i_ready) begin
        check("result", longint'($signed(o_result)), longint'(exp_q.pop_front()));
        total_acc++;
        last_acc_cyc = cyc;
      end else begin
        check("stall_hold", longint'($signed(o_result)), longint'(exp_q[0]));
      end
    end
  end

  // Ready driver: optional directed stall on one window, optional random backpressure.
  initial begin
    int seen_run = -1;
    int st_cnt = 0;
    i_ready = 1'b1;
    forever begin
      @(posedge i_clk);
      #1;
      if (run_id != seen_run) begin
        seen_run = run_id;
        st_cnt = 0;
      end
      if (o_valid && (total_acc - acc_base == st_win) && st_cnt < st_len) begin
        i_ready = 1'b0;
        st_cnt++;
      end else if (rand_ready) begin
        i_ready = ($urandom_range(0, 3) != 0);
      end else begin
        i_ready = 1'b1;
      end
    end
  end

  task automatic start_run(input int kb, input int wb, input int n, input int sh,
                           input bit relu, input int fixed_exp);
    for (int w = 0; w < n; w++) begin
      if (fixed_exp != NOFIX) exp_q.push_back(fixed_exp);
      else exp_q.push_back(ref_window(kb, wb, w, sh, relu));
    end
    acc_base = total_acc;
    run_id++;
    @(negedge i_clk);
    i_kernel_base = 8'(kb);
    i_win_base    = 8'(wb);
    i_num_windows = 8'(n);
    i_shift       = 5'(sh);
    i_relu_en     = relu;
    i_start       = 1'b1;
    @(posedge i_clk);
    #1;
    start_cyc = cyc;
    // Configuration must be latched; scramble it right away.
    i_start       = 1'b0;
    i_kernel_base = 8'($urandom);
    i_win_base    = 8'($urandom);
    i_num_windows = 8'($urandom);
    i_shift       = 5'($urandom);
    i_relu_en     = 1'($urandom);
  endtask

  task automatic finish_run(input int n, input bit chk_lat, input int extra);
    int busy_cnt = 0;
    int kchg = 0;
    int idx = 0;
    int done_cyc = 0;
    int exp_lat;
    bit got = 1'b0;
    logic [7:0] prev_ka;
    prev_ka = o_kernel_addr;
    exp_lat = (n == 0) ? 1 : (TAPS + 1) + n * (TAPS + 2) + 1 + extra;
    for (int c = 0; c < 3000; c++) begin
      @(negedge i_clk);
      idx = cyc - start_cyc + 1;
      // A start pulse while busy must be ignored.
      i_start = (c == 3 && n > 0);
      if (o_busy) busy_cnt++;
      if (idx > TAPS + 1 && o_kernel_addr != prev_ka) kchg++;
      prev_ka = o_kernel_addr;
      if (o_done) begin
        got = 1'b1;
        done_cyc = cyc;
        break;
      end
    end
    i_start = 1'b0;
    if (!got) begin
      n_cmp++;
      n_err++;
      $display("FAIL done_timeout: got no o_done, expected one within 3000 cycles");
      exp_q.delete();
      return;
    end
    check("accept_count", total_acc - acc_base, n);
    check("queue_drained", exp_q.size(), 0);
    check("kernel_reread", kchg, 0);
    if (n > 0) check("done_after_accept", done_cyc, last_acc_cyc + 1);
    if (chk_lat) begin
      check("latency", idx, exp_lat);
      check("busy_cycles", busy_cnt, exp_lat);
    end
    @(negedge i_clk);
    check("done_one_cycle", o_done, 0);
    check("busy_idle", o_busy, 0);
  endtask

  task automatic fill_k(input int base, input int val);
    for (int t = 0; t < TAPS; t++) kmem[(base + t) % 256] = 8'(val);
  endtask

  task automatic fill_w_seq(input int base);
    for (int t = 0; t < TAPS; t++) wmem[(base + t) % 256] = 8'(t + 1);
  endtask

  task automatic fill_random();
    for (int i = 0; i < 256; i++) begin
      kmem[i] = 8'($urandom);
      wmem[i] = 8'($urandom);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_result"}, o_result, 0);
    check({tag, "_valid"}, o_valid, 0);
    check({tag, "_busy"}, o_busy, 0);
    check({tag, "_done"}, o_done, 0);
    check({tag, "_kaddr"}, o_kernel_addr, 0);
    check({tag, "_waddr"}, o_win_addr, 0);
  endtask

  initial begin
    int kb;
    int wb;
    int n;
    int dcnt;
    int bcnt;
    bit got;
    i_rst = 1'b1;
    i_start = 1'b0;
    i_kernel_base = '0;
    i_win_base = '0;
    i_num_windows = '0;
    i_shift = '0;
    i_relu_en = 1'b0;
    for (int i = 0; i < 256; i++) begin
      kmem[i] = '0;
      wmem[i] = '0;
    end
    repeat (3) @(negedge i_clk);
    check_outputs_zero("reset");
    i_rst = 1'b0;

    // Zero windows: straight to finish, no reads issued.
    start_run(8'h20, 8'h30, 0, 0, 1'b0, NOFIX);
    finish_run(0, 1'b1, 0);
    check("n0_kaddr", o_kernel_addr, 0);
    check("n0_waddr", o_win_addr, 0);

    // Directed windows.
    fill_k(8'h10, 1);
    fill_w_seq(8'h40);
    start_run(8'h10, 8'h40, 1, 0, 1'b0, 45);
    finish_run(1, 1'b1, 0);
    start_run(8'h10, 8'h40, 1, 2, 1'b0, 11);
    finish_run(1, 1'b1, 0);
    fill_k(8'h10, -1);
    start_run(8'h10, 8'h40, 1, 0, 1'b0, -45);
    finish_run(1, 1'b1, 0);
    start_run(8'h10, 8'h40, 1, 0, 1'b1, 0);
    finish_run(1, 1'b1, 0);
    fill_k(8'h10, 127);
    for (int t = 0; t < TAPS; t++) wmem[8'h40 + t] = 8'd127;
    start_run(8'h10, 8'h40, 1, 0, 1'b0, 127);
    finish_run(1, 1'b1, 0);
    fill_k(8'h10, -128);
    start_run(8'h10, 8'h40, 1, 0, 1'b0, -128);
    finish_run(1, 1'b1, 0);

    // Three windows with a 5-cycle stall on window 1.
    fill_random();
    st_win = 1;
    st_len = 5;
    start_run(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 3,
              int'($urandom_range(0, 10)), 1'($urandom), NOFIX);
    finish_run(3, 1'b1, 5);
    st_win = -1;
    st_len = 0;

    // Address wrap in both banks.
    start_run(8'hFC, 8'hF8, 3, 6, 1'b0, NOFIX);
    finish_run(3, 1'b1, 0);

    // Random runs with random backpressure.
    rand_ready = 1'b1;
    for (int r = 0; r < 6; r++) begin
      fill_random();
      n = int'($urandom_range(1, 5));
      start_run(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), n,
                int'($urandom_range(0, 14)), 1'($urandom), NOFIX);
      finish_run(n, 1'b0, 0);
    end
    rand_ready = 1'b0;

    // Reset during MAC of window 1 of 4.
    fill_random();
    kb = int'($urandom_range(0, 255));
    wb = int'($urandom_range(0, 255));
    start_run(kb, wb, 4, 8, 1'b0, NOFIX);
    got = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge i_clk);
      if (total_acc - acc_base >= 1) begin
        got = 1'b1;
        break;
      end
    end
    check("rst_first_accept_seen", got, 1);
    repeat (3) @(negedge i_clk);
    i_rst = 1'b1;
    #1;
    check_outputs_zero("midrst");
    exp_q.delete();
    @(negedge i_clk);
    i_rst = 1'b0;
    dcnt = 0;
    bcnt = 0;
    repeat (30) begin
      @(negedge i_clk);
      if (o_done) dcnt++;
      if (o_busy) bcnt++;
    end
    check("midrst_no_done", dcnt, 0);
    check("midrst_idle", bcnt, 0);

    // Fresh run after the abort.
    start_run(kb, wb, 2, 7, 1'b1, NOFIX);
    finish_run(2, 1'b1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion, expected finish before 2 ms");
    $fatal(1, "watchdog expired");
  end

endmodule
